conn_arb: RTL and testbench

- Merges the connection streams of NUM_LANES parallel pairwise-distance lanes into one conn_t stream with valid/ready, feeding the downstream sort/union stage.
- Lane outputs have no backpressure, so each lane gets a small FIFO. A stall output throttles that lane's point loading before its FIFO overflows.
- A round-robin arbiter drains the FIFOs into a registered output stage.

---
 rtl/aoc_types_pkg.sv | 18 +
 rtl/conn_fifo.sv | 50 +++++
 rtl/conn_arb.sv | 108 ++++++++++
 tb/tb_conn_arb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_types_pkg.sv
// Shared types for the pairwise-distance pipeline.
//   conn_t      : one candidate connection (distance, pointa, pointb)
//   conn_lane_t : lane index type for the default lane count
package aoc_types_pkg;

  localparam int DIST_W     = 32;
  localparam int PT_W       = 16;
  localparam int CONN_LANES = 4;

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [PT_W-1:0]   pointa;
    logic [PT_W-1:0]   pointb;
  } conn_t;

  typedef logic [$clog2(CONN_LANES)-1:0] conn_lane_t;

endpackage

// File: rtl/conn_fifo.sv
// Per-lane synchronous FIFO of conn_t, power-of-2 depth.
//   clk, rst_n : clock, async active-low reset (pointers only)
//   push, din  : write request/data; accepted when not full, or full and popping
//   pop, dout  : read request/head entry (dout valid whenever !empty)
//   full, empty, count : occupancy status
module conn_fifo
  import aoc_types_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  conn_t       din,
  output conn_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  conn_t       mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Extra pointer MSB tells full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conn_arb.sv
// Merges NUM_LANES distance-lane connection streams into one valid/ready stream.
//   clk, rst_n      : clock, async active-low reset
//   in_conn, in_vld : per-lane entries, no backpressure (accepted or dropped)
//   lane_stall      : per-lane throttle, high when FIFO nearly full
//   out_conn, out_lane, out_vld, out_rdy : registered output stage
//   ovf_err         : sticky, an entry was dropped on a full FIFO
//   conn_cnt        : saturating count of output handshakes
module conn_arb
  import aoc_types_pkg::*;
#(
  parameter  int NUM_LANES    = 4,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int STALL_MARGIN = 2,
  parameter  int CNT_W        = 20,
  localparam int LANE_W       = $clog2(NUM_LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  conn_t [NUM_LANES-1:0]      in_conn,
  input  logic  [NUM_LANES-1:0]      in_vld,
  output logic  [NUM_LANES-1:0]      lane_stall,
  output conn_t                      out_conn,
  output logic  [LANE_W-1:0]         out_lane,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       ovf_err,
  output logic  [CNT_W-1:0]          conn_cnt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int THR = FIFO_DEPTH - STALL_MARGIN;

  logic  [NUM_LANES-1:0]         full, empty, pop, push_ok, stall_nxt;
  logic  [NUM_LANES-1:0][CW-1:0] count;
  logic  [CW:0]                  cnt_nxt [NUM_LANES];
  conn_t [NUM_LANES-1:0]         head;
  logic  [LANE_W-1:0]            last_grant, gnt;
  logic                          gnt_vld, load;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    conn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_vld[g]),
      .pop   (pop[g]),
      .din   (in_conn[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (count[g])
    );
  end

  // Round-robin: start one past last_grant, last_grant itself checked last.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(last_grant) + k) % NUM_LANES;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = LANE_W'(idx);
      end
    end
  end

  assign load = (!out_vld || out_rdy) && gnt_vld;

  always_comb begin
    pop      = '0;
    pop[gnt] = load;
  end

  // Occupancy after this cycle's push/pop drives the registered stall.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      push_ok[i]   = in_vld[i] && (!full[i] || pop[i]);
      cnt_nxt[i]   = {1'b0, count[i]} + (CW+1)'(push_ok[i]) - (CW+1)'(pop[i]);
      stall_nxt[i] = (cnt_nxt[i] >= (CW+1)'(THR));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_conn   <= '0;
      out_lane   <= '0;
      out_vld    <= 1'b0;
      last_grant <= LANE_W'(NUM_LANES-1);
      lane_stall <= '0;
      ovf_err    <= 1'b0;
      conn_cnt   <= '0;
    end else begin
      if (load) begin
        out_conn   <= head[gnt];
        out_lane   <= gnt;
        out_vld    <= 1'b1;
        last_grant <= gnt;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
      lane_stall <= stall_nxt;
      if (|(in_vld & full & ~pop)) ovf_err <= 1'b1;
      if (out_vld && out_rdy && (conn_cnt != '1)) conn_cnt <= conn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conn_arb.sv
module tb_conn_arb;
  import aoc_types_pkg::*;

  localparam int NL = 4, FD = 8, SM = 2, CW = 4;

  logic              clk = 1'b0, rst_n = 1'b0;
  conn_t [NL-1:0]    in_conn;
  logic  [NL-1:0]    in_vld, lane_stall;
  conn_t             out_conn;
  logic  [1:0]       out_lane;
  logic              out_vld, out_rdy, ovf_err;
  logic  [CW-1:0]    conn_cnt;

  int n_tests = 0, n_fail = 0, cyc = 0;
  conn_t got_conn[$];
  int    got_lane[$];
  int    got_cyc[$];

  conn_arb #(.NUM_LANES(NL), .FIFO_DEPTH(FD), .STALL_MARGIN(SM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_conn(in_conn), .in_vld(in_vld),
    .lane_stall(lane_stall), .out_conn(out_conn), .out_lane(out_lane),
    .out_vld(out_vld), .out_rdy(out_rdy), .ovf_err(ovf_err), .conn_cnt(conn_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      got_conn.push_back(out_conn);
      got_lane.push_back(int'(out_lane));
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic conn_t mk(int d, int a, int b);
    conn_t c;
    c.distance = 32'(d);
    c.pointa   = 16'(a);
    c.pointb   = 16'(b);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_conn.delete();
    got_lane.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_vld  = '0;
    in_conn = '0;
    out_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    clear_q();
  endtask

  task automatic wait_got(string tag, int n, int budget);
    for (int i = 0; i < budget && got_conn.size() < n; i++) step();
    chk(tag, got_conn.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_conn", out_conn, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_stall", lane_stall, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_cnt", conn_cnt, 0);

    // Single entry latency
    out_rdy    = 1'b1;
    in_conn[2] = mk(25, 3, 7);
    in_vld     = 4'b0100;
    step();
    in_vld = '0;
    chk("lat_c1_vld", out_vld, 0);
    step();
    chk("lat_c2_vld", out_vld, 1);
    chk("lat_data", out_conn, mk(25, 3, 7));
    chk("lat_lane", out_lane, 2);
    step();
    chk("lat_cnt", conn_cnt, 1);
    chk("lat_vld_drop", out_vld, 0);

    // Fairness
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < NL; l++) in_conn[l] = mk(100 * l + c, l, c);
      in_vld = '1;
      step();
    end
    in_vld = '0;
    wait_got("fair_n", 12, 40);
    if (got_conn.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("fair_lane%0d", k), got_lane[k], k % 4);
        chk($sformatf("fair_data%0d", k), got_conn[k], mk(100 * (k % 4) + k / 4, k % 4, k / 4));
      end
      chk("fair_b2b", got_cyc[11] - got_cyc[0], 11);
    end
    chk("fair_cnt", conn_cnt, 12);

    // Backpressure
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in_conn[0] = mk(200 + c, c, 0);
      in_vld     = 4'b0001;
      step();
    end
    in_vld = '0;
    chk("bp_vld", out_vld, 1);
    chk("bp_hold0", out_conn, mk(200, 0, 0));
    chk("bp_stall", lane_stall[0], 0);
    step();
    step();
    chk("bp_hold1", out_conn, mk(200, 0, 0));
    out_rdy = 1'b1;
    wait_got("bp_n", 5, 20);
    if (got_conn.size() == 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("bp_data%0d", k), got_conn[k], mk(200 + k, k, 0));
      chk("bp_b2b", got_cyc[4] - got_cyc[0], 4);
    end

    // Stall and overflow
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_conn[1] = mk(300 + c, c, 1);
      in_vld     = 4'b0010;
      step();
      if (c == 5) chk("st_below", lane_stall[1], 0);
      if (c == 6) chk("st_at6", lane_stall[1], 1);
      if (c == 8) chk("st_ovf_pre", ovf_err, 0);
    end
    in_vld = '0;
    chk("st_ovf", ovf_err, 1);
    chk("st_full", dut.g_lane[1].u_fifo.count, 8);
    out_rdy = 1'b1;
    wait_got("st_n", 9, 30);
    if (got_conn.size() == 9)
      for (int k = 0; k < 9; k++) chk($sformatf("st_data%0d", k), got_conn[k], mk(300 + k, k, 1));
    step();
    step();
    chk("st_no10", got_conn.size(), 9);
    chk("st_sticky", ovf_err, 1);
    chk("st_stall_clr", lane_stall[1], 0);

    // Full with simultaneous pop/push
    do_reset();
    for (int c = 0; c < 9; c++) begin
      in_conn[3] = mk(400 + c, c, 3);
      in_vld     = 4'b1000;
      step();
    end
    chk("fp_full", dut.g_lane[3].u_fifo.count, 8);
    out_rdy = 1'b1;
    for (int c = 9; c < 15; c++) begin
      in_conn[3] = mk(400 + c, c, 3);
      step();
      chk($sformatf("fp_occ%0d", c), dut.g_lane[3].u_fifo.count, 8);
    end
    in_vld = '0;
    chk("fp_ovf", ovf_err, 0);
    wait_got("fp_n", 15, 30);
    if (got_conn.size() == 15) begin
      for (int k = 0; k < 15; k++) chk($sformatf("fp_data%0d", k), got_conn[k], mk(400 + k, k, 3));
      chk("fp_b2b", got_cyc[6] - got_cyc[0], 6);
    end

    // Counter saturation
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_conn[2] = mk(500 + c, c, 2);
      in_vld     = 4'b0100;
      step();
    end
    in_vld = '0;
    wait_got("sat_n", 20, 30);
    chk("sat_cnt", conn_cnt, 15);

    // Reset mid-operation
    do_reset();
    out_rdy    = 1'b1;
    in_conn[0] = mk(1, 1, 1);
    in_vld     = 4'b0001;
    step();
    in_vld = '0;
    step();
    step();
    chk("mr_cnt_pre", conn_cnt, 1);
    out_rdy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      for (int l = 1; l < NL; l++) in_conn[l] = mk(900 + c, l, c);
      in_vld = 4'b1110;
      step();
    end
    in_vld = '0;
    chk("mr_vld_pre", out_vld, 1);
    chk("mr_stall_pre", lane_stall, 4'b1110);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_vld", out_vld, 0);
    chk("mr_stall", lane_stall, 0);
    chk("mr_ovf", ovf_err, 0);
    chk("mr_cnt", conn_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    clear_q();
    out_rdy = 1'b1;
    step();
    step();
    step();
    chk("mr_nostale", got_conn.size(), 0);
    for (int l = 0; l < NL; l++) in_conn[l] = mk(600 + l, l, 0);
    in_vld = '1;
    step();
    in_vld = '0;
    wait_got("mr_n", 4, 20);
    if (got_conn.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("mr_lane%0d", k), got_lane[k], k);
        chk($sformatf("mr_data%0d", k), got_conn[k], mk(600 + k, k, 0));
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
